// File: rtl/wishbone_register_bank.sv
// Wishbone register bank: NUM_REGS 32-bit registers with per-bit read-only,
// live-readback and sticky (write-1-to-clear) behaviour. Single-cycle
// response followed by one dead cycle before the next transfer is accepted.
module wishbone_register_bank #(
  parameter int                     NUM_REGS        = 4,
  parameter int                     ADDR_WIDTH      = 4,
  parameter logic [NUM_REGS*32-1:0] INITIAL_VALUES  = '0,
  parameter logic [NUM_REGS*32-1:0] READ_ONLY_MASKS = '0,
  parameter logic [NUM_REGS*32-1:0] LIVE_MASKS      = '0,
  parameter logic [NUM_REGS*32-1:0] STICKY_MASKS    = '0
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  input  logic                     in_wb_cyc,
  input  logic                     in_wb_stb,
  input  logic                     in_wb_we,
  input  logic [ADDR_WIDTH-1:0]    in_wb_adr,
  input  logic [3:0]               in_wb_sel,
  input  logic [31:0]              in_wb_dat,
  output logic                     out_wb_ack,
  output logic                     out_wb_err,
  output logic [31:0]              out_wb_dat,
  output logic [NUM_REGS*32-1:0]   out_contents,
  input  logic [NUM_REGS*32-1:0]   in_live_values,
  output logic [NUM_REGS-1:0]      out_write_strobe
);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_GAP} state_t;

  localparam logic [NUM_REGS-1:0][31:0] INIT_A = INITIAL_VALUES;
  localparam logic [NUM_REGS-1:0][31:0] RO_A   = READ_ONLY_MASKS;
  localparam logic [NUM_REGS-1:0][31:0] LV_A   = LIVE_MASKS;
  localparam logic [NUM_REGS-1:0][31:0] ST_A   = STICKY_MASKS;
  localparam logic [31:0]               NREGS  = 32'(NUM_REGS);

  state_t                     state_q, state_d;
  logic [NUM_REGS-1:0][31:0]  contents_q, contents_d;
  logic [NUM_REGS-1:0][31:0]  live_a;
  logic [NUM_REGS-1:0]        strobe_q, strobe_d;
  logic [31:0]                rdat_q, rdat_d;
  logic                       err_q, err_d;

  logic [31:0] adr_ext;
  logic        in_range;
  logic        req;
  logic        wr_req;
  logic [31:0] lane_mask;
  logic [31:0] rd_val;

  assign live_a    = in_live_values;
  assign adr_ext   = 32'(in_wb_adr);
  assign in_range  = adr_ext < NREGS;
  // A transfer is only accepted from IDLE; stb during GAP is ignored.
  assign req       = in_wb_cyc & in_wb_stb & (state_q == S_IDLE);
  assign wr_req    = req & in_wb_we & in_range;
  assign lane_mask = {{8{in_wb_sel[3]}}, {8{in_wb_sel[2]}},
                      {8{in_wb_sel[1]}}, {8{in_wb_sel[0]}}};

  // State register
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: dropping cyc abandons RESP/GAP immediately
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_wb_cyc && in_wb_stb) state_d = S_RESP;
      S_RESP: state_d = in_wb_cyc ? S_GAP : S_IDLE;
      S_GAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs: only visible in RESP while cyc is held
  always_comb begin
    out_wb_ack = 1'b0;
    out_wb_err = 1'b0;
    out_wb_dat = '0;
    if (in_wb_cyc && state_q == S_RESP) begin
      out_wb_ack = ~err_q;
      out_wb_err = err_q;
      out_wb_dat = rdat_q;
    end
  end

  // Per-register next value: write merge, sticky clear/set, read-only pinning
  always_comb begin
    logic        hit;
    logic [31:0] wm, nrm, clr, cur;
    contents_d = contents_q;
    strobe_d   = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      hit = wr_req && (adr_ext == 32'(k));
      wm  = hit ? lane_mask : '0;
      nrm = wm & ~RO_A[k] & ~ST_A[k];
      clr = wm & ST_A[k] & in_wb_dat;
      cur = (contents_q[k] & ~nrm) | (in_wb_dat & nrm);
      cur = cur & ~clr;
      // set applied after clear so a coincident live bit wins
      cur = cur | (live_a[k] & ST_A[k]);
      cur = (cur & ~RO_A[k]) | (INIT_A[k] & RO_A[k]);
      contents_d[k] = cur;
      strobe_d[k]   = hit;
    end
  end

  // Read mux: live bits come from the input, the rest from storage
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (adr_ext == 32'(k))
        rd_val = (live_a[k] & LV_A[k]) | (contents_q[k] & ~LV_A[k]);
    end
  end

  // Response capture at the request edge
  always_comb begin
    rdat_d = rdat_q;
    err_d  = err_q;
    if (req) begin
      rdat_d = (!in_wb_we && in_range) ? rd_val : '0;
      err_d  = ~in_range;
    end
  end

  // Datapath registers
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      contents_q <= INIT_A;
      strobe_q   <= '0;
      rdat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      contents_q <= contents_d;
      strobe_q   <= strobe_d;
      rdat_q     <= rdat_d;
      err_q      <= err_d;
    end
  end

  assign out_contents     = contents_q;
  assign out_write_strobe = strobe_q;

endmodule

// File: doc/wishbone_register_bank.md
WISHBONE_REGISTER_BANK -- requirements
Module: wishbone_register_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of 32-bit registers, range 1..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: word-address width; 2**ADDR_WIDTH >= NUM_REGS.
REQ-003 SHALL have parameter INITIAL_VALUES, default 0: NUM_REGS*32 bits; register k is at bits [k*32 +: 32].
REQ-004 SHALL have parameter READ_ONLY_MASKS, default 0: same packing; a 1 makes that bit non-writable and fixes it at its INITIAL_VALUES bit.
REQ-005 SHALL have parameter LIVE_MASKS, default 0: same packing; a 1 makes that bit read the in_live_values bit instead of stored contents.
REQ-006 SHALL have parameter STICKY_MASKS, default 0: same packing; a 1 makes that bit sticky status (set by live input, write-1-to-clear).
REQ-007 in_clock  input  1  sole clock; all state changes on its rising edge.
REQ-008 in_reset  input  1  asynchronous, active-high reset.
REQ-009 in_wb_cyc  input  1  bus cycle valid.
REQ-010 in_wb_stb  input  1  strobe.
REQ-011 in_wb_we  input  1  1 = write, 0 = read.
REQ-012 in_wb_adr  input  ADDR_WIDTH  register word index.
REQ-013 in_wb_sel  input  4  byte lane enables.
REQ-014 in_wb_dat  input  32  write data.
REQ-015 out_wb_ack  output  1  transfer acknowledge.
REQ-016 out_wb_err  output  1  error acknowledge for out-of-range address.
REQ-017 out_wb_dat  output  32  read data.
REQ-018 out_contents  output  NUM_REGS*32  stored contents of all registers.
REQ-019 in_live_values  input  NUM_REGS*32  live and sticky-source values.
REQ-020 out_write_strobe  output  NUM_REGS  one-cycle pulse per written register.

Function
REQ-021 SHALL implement FSM IDLE -> RESP -> GAP -> IDLE; in IDLE, a request (cyc & stb) at an edge moves the FSM to RESP.
REQ-022 In RESP, SHALL assert exactly one of out_wb_ack (adr < NUM_REGS) or out_wb_err (adr >= NUM_REGS) for one cycle. Latency is one cycle from the request edge.
REQ-023 In GAP, SHALL hold ack/err low and ignore stb; any stb still high in the following IDLE cycle starts a new transfer.
REQ-024 Write, in range: SHALL commit at the request edge, per byte lane with in_wb_sel[i] = 1 -> bits [i*8 +: 8].
REQ-025 Non-sticky, non-read-only bits SHALL take in_wb_dat. Read-only bits SHALL keep INITIAL_VALUES. Sticky bits SHALL clear where the written bit is 1.
REQ-026 Sticky bit SHALL set on any edge where its in_live_values bit is 1. When set and write-1-clear coincide, set wins.
REQ-027 Write, in range: SHALL pulse out_write_strobe[adr] high during the RESP cycle only, even when in_wb_sel = 0.
REQ-028 Read: SHALL register out_wb_dat at the request edge as (in_live_values & LIVE_MASKS) | (contents & ~LIVE_MASKS) for the addressed register, with in_wb_sel ignored.
REQ-029 out_wb_dat SHALL be 0 outside RESP, and 0 for out-of-range reads.
REQ-030 Out-of-range writes SHALL change no register and pulse no strobe.
REQ-031 If in_wb_cyc is low, SHALL force out_wb_ack, out_wb_err and out_wb_dat to 0 combinationally. If cyc is low in RESP or GAP, the FSM SHALL return to IDLE at the next edge; an already-committed write is not undone.
REQ-032 out_contents SHALL reflect stored values; LIVE_MASKS bits show stored contents, not live values.

Reset
REQ-033 in_reset high SHALL immediately set: FSM to IDLE; out_contents to INITIAL_VALUES; out_wb_ack, out_wb_err, out_write_strobe and out_wb_dat to 0.
REQ-034 Reset mid-transfer SHALL drop ack/err the same cycle and discard the transfer; the first request after release gets normal latency.

Verification
REQ-035 Reset with INITIAL_VALUES reg1 = 0x12345678, then read adr 1 -> ack one cycle after request, out_wb_dat = 0x12345678, then 0.
REQ-036 Write adr 2, sel 0b0101, dat 0xAABBCCDD over 0 -> reg2 = 0x00BB00DD, out_write_strobe = 0b0100 for one cycle.
REQ-037 READ_ONLY_MASKS reg0 = 0xFF000000, INITIAL reg0 = 0x5A000000; write 0xFFFFFFFF -> reg0 = 0x5AFFFFFF.
REQ-038 STICKY_MASKS reg3 bit0: pulse live bit0 -> bit stays 1; write 0x1 while live bit0 = 1 -> stays 1; write 0x1 with live 0 -> clears.
REQ-039 Read adr 7 with NUM_REGS = 4 -> out_wb_err one cycle, ack 0, dat 0; write adr 7 -> no contents change.
REQ-040 Assert in_reset during RESP -> ack low same cycle, contents = INITIAL_VALUES; next read gets normal one-cycle latency.
